// File: rtl/sliding_tile_pkg.sv
// Shared definitions for the sliding-tile puzzle: move encodings, the reset
// position of the space, and helpers for legality and stepping the space.
package sliding_tile_pkg;

  localparam logic [1:0] LEFT  = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] UP    = 2'b10;
  localparam logic [1:0] DOWN  = 2'b11;

  // Space location is {row[1:0], col[1:0]}; bottom right of the 3x3 board.
  localparam logic [3:0] SPACE_RESET = 4'b1010;

  // Moves pair up as LEFT/RIGHT and UP/DOWN: same upper bit, different lower bit.
  function automatic logic is_reverse(input logic [1:0] dir_a, input logic [1:0] dir_b);
    logic result;
    result = (dir_a[1] == dir_b[1]) && (dir_a[0] != dir_b[0]);
    return result;
  endfunction

  // True when the space can move in the given direction without leaving the board.
  function automatic logic in_bounds(input logic [1:0] dir, input logic [3:0] loc);
    logic result;
    result = 1'b0;
    case (dir)
      LEFT:    result = (loc[1:0] != 2'd0);
      RIGHT:   result = (loc[1:0] <  2'd2);
      UP:      result = (loc[3:2] != 2'd0);
      default: result = (loc[3:2] <  2'd2);
    endcase
    return result;
  endfunction

  // Location of the space after a move; only meaningful for in-bounds moves.
  function automatic logic [3:0] step_loc(input logic [1:0] dir, input logic [3:0] loc);
    logic [3:0] result;
    result = loc;
    case (dir)
      LEFT:    result[1:0] = loc[1:0] - 2'd1;
      RIGHT:   result[1:0] = loc[1:0] + 2'd1;
      UP:      result[3:2] = loc[3:2] - 2'd1;
      default: result[3:2] = loc[3:2] + 2'd1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/sliding_tile_move_fifo.sv
// Small synchronous FIFO holding pending 2-bit move commands.
// Pushes while full and pops while empty are ignored.
module sliding_tile_move_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array needs no reset; the occupancy count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sliding_tile_move_sequencer.sv
// Buffers incoming moves, vets each one against the tracked space position and
// the previously issued move, and presents only legal moves to the puzzle core.
import sliding_tile_pkg::*;

module sliding_tile_move_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_in_val,
  output logic             move_in_rdy,
  input  logic [1:0]       move_in_dir,
  output logic             dir_out_val,
  input  logic             dir_out_rdy,
  output logic [1:0]       dir_out,
  output logic             move_err,
  output logic [CNT_W-1:0] move_count,
  output logic [3:0]       space_loc
);

  logic       fifo_full;
  logic       fifo_empty;
  logic [1:0] head_dir;
  logic       load;
  logic       head_legal;
  logic [1:0] last_dir;
  logic       last_vld;

  // Full flag comes straight from the FIFO's registered count, so there is no
  // combinational path from dir_out_rdy back to move_in_rdy.
  assign move_in_rdy = !fifo_full;

  // The head is consumed whenever the output slot is free or being emptied.
  assign load = (!dir_out_val || dir_out_rdy) && !fifo_empty;

  assign head_legal = in_bounds(head_dir, space_loc) &&
                      !(last_vld && is_reverse(head_dir, last_dir));

  sliding_tile_move_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (move_in_val && move_in_rdy),
    .push_data (move_in_dir),
    .pop       (load),
    .pop_data  (head_dir),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output register and space tracker: legal heads are issued, illegal ones dropped with a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_out     <= LEFT;
      dir_out_val <= 1'b0;
      move_err    <= 1'b0;
      space_loc   <= SPACE_RESET;
      last_dir    <= LEFT;
      last_vld    <= 1'b0;
    end else begin
      move_err <= 1'b0;
      if (load) begin
        if (head_legal) begin
          dir_out     <= head_dir;
          dir_out_val <= 1'b1;
          space_loc   <= step_loc(head_dir, space_loc);
          last_dir    <= head_dir;
          last_vld    <= 1'b1;
        end else begin
          move_err    <= 1'b1;
          dir_out_val <= 1'b0;
        end
      end else if (dir_out_rdy) begin
        dir_out_val <= 1'b0;
      end
    end
  end

  // Count moves taken by the puzzle core, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_count <= '0;
    end else if (dir_out_val && dir_out_rdy && (move_count != {CNT_W{1'b1}})) begin
      move_count <= move_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sliding_tile_move_sequencer.sv
// Self-checking bench for sliding_tile_move_sequencer. A reference model of the
// board computes each accepted move's outcome and queues the expected issued
// moves; a monitor pops and compares them at every dir_out handshake.
module tb_sliding_tile_move_sequencer;

  localparam logic [1:0] M_L = 2'b00;
  localparam logic [1:0] M_R = 2'b01;
  localparam logic [1:0] M_U = 2'b10;
  localparam logic [1:0] M_D = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        move_in_val = 1'b0;
  logic        move_in_rdy;
  logic [1:0]  move_in_dir = 2'b00;
  logic        dir_out_val;
  logic        dir_out_rdy = 1'b0;
  logic [1:0]  dir_out;
  logic        move_err;
  logic [15:0] move_count;
  logic [3:0]  space_loc;

  // Narrow-counter instance for the saturation scenario.
  logic        s_val = 1'b0;
  logic        s_in_rdy;
  logic [1:0]  s_dir = 2'b00;
  logic        s_out_val;
  logic [1:0]  s_out;
  logic        s_err;
  logic [1:0]  s_count;
  logic [3:0]  s_loc;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int         m_row;
  int         m_col;
  logic [1:0] m_last;
  logic       m_last_vld;
  logic [5:0] exp_q[$];
  int         err_exp;
  int         err_seen;

  always #5 clk = ~clk;

  sliding_tile_move_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .move_in_val (move_in_val),
    .move_in_rdy (move_in_rdy),
    .move_in_dir (move_in_dir),
    .dir_out_val (dir_out_val),
    .dir_out_rdy (dir_out_rdy),
    .dir_out     (dir_out),
    .move_err    (move_err),
    .move_count  (move_count),
    .space_loc   (space_loc)
  );

  sliding_tile_move_sequencer #(.DEPTH(4), .CNT_W(2)) sat_dut (
    .clk         (clk),
    .reset       (reset),
    .move_in_val (s_val),
    .move_in_rdy (s_in_rdy),
    .move_in_dir (s_dir),
    .dir_out_val (s_out_val),
    .dir_out_rdy (1'b1),
    .dir_out     (s_out),
    .move_err    (s_err),
    .move_count  (s_count),
    .space_loc   (s_loc)
  );

  // Monitor: count error pulses and compare every handshake against the scoreboard.
  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset) begin
      if (move_err) err_seen++;
      if (dir_out_val && dir_out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_move: got dir=%b loc=%b, required no move", dir_out, space_loc);
        end else begin
          e = exp_q.pop_front();
          if ({dir_out, space_loc} !== e) begin
            errors++;
            $display("[TB] FAIL handshake: got dir=%b loc=%b, required dir=%b loc=%b",
                     dir_out, space_loc, e[5:4], e[3:0]);
          end
        end
      end
    end
  end

  // Independent board model: decide legality and queue the expected outcome.
  task automatic model_accept(input logic [1:0] d);
    bit ok;
    int nr, nc;
    nr = m_row;
    nc = m_col;
    case (d)
      M_L: begin ok = (m_col > 0); nc = m_col - 1; end
      M_R: begin ok = (m_col < 2); nc = m_col + 1; end
      M_U: begin ok = (m_row > 0); nr = m_row - 1; end
      default: begin ok = (m_row < 2); nr = m_row + 1; end
    endcase
    if (m_last_vld && ((d == M_L && m_last == M_R) || (d == M_R && m_last == M_L) ||
                       (d == M_U && m_last == M_D) || (d == M_D && m_last == M_U)))
      ok = 0;
    if (ok) begin
      m_row = nr;
      m_col = nc;
      m_last = d;
      m_last_vld = 1'b1;
      exp_q.push_back({d, 2'(nr), 2'(nc)});
    end else begin
      err_exp++;
    end
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1'b1;
    move_in_val = 1'b0;
    s_val = 1'b0;
    dir_out_rdy = rdy;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_row = 2;
    m_col = 2;
    m_last = M_L;
    m_last_vld = 1'b0;
    err_exp = 0;
    err_seen = 0;
  endtask

  // Offer one move and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [1:0] d);
    bit done;
    done = 0;
    move_in_val = 1'b1;
    move_in_dir = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (move_in_rdy) begin
        @(posedge clk);
        model_accept(d);
        done = 1;
      end
    end
    #1;
    move_in_val = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got move_in_rdy=0 for 100 cycles, required 1");
    end
  endtask

  // Wait for the scoreboard and the output slot to empty, then check error pulses.
  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !dir_out_val) done = 1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d moves pending, required 0", exp_q.size());
    end
    checks++;
    if (err_seen !== err_exp) begin
      errors++;
      $display("[TB] FAIL err_pulses: got %0d, required %0d", err_seen, err_exp);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    @(negedge clk);
    checks++;
    if ({move_in_rdy, dir_out_val, dir_out, move_err} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got rdy/val/dir/err=%b, required 10000",
               {move_in_rdy, dir_out_val, dir_out, move_err});
    end
    checks++;
    if (move_count !== 16'd0 || space_loc !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL reset_state: got count=%0d loc=%b, required 0 1010", move_count, space_loc);
    end
  endtask

  task automatic test_basic();
    do_reset(1'b1);
    applyStimulus(M_U);
    @(negedge clk);
    checks++;
    if (dir_out_val !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got dir_out_val=%b, required 0", dir_out_val);
    end
    @(negedge clk);
    checks++;
    if (dir_out_val !== 1'b1 || dir_out !== M_U) begin
      errors++;
      $display("[TB] FAIL latency: got val=%b dir=%b, required 1 10", dir_out_val, dir_out);
    end
    @(posedge clk);
    #1;
    applyStimulus(M_L);
    drain();
    checks++;
    if (move_count !== 16'd2 || space_loc !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL basic_final: got count=%0d loc=%b, required 2 0101", move_count, space_loc);
    end
  endtask

  task automatic test_off_edge();
    do_reset(1'b1);
    applyStimulus(M_R);
    @(negedge clk);
    checks++;
    if (move_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_early: got move_err=%b, required 0", move_err);
    end
    @(negedge clk);
    checks++;
    if (move_err !== 1'b1 || dir_out_val !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_pulse: got err=%b val=%b, required 1 0", move_err, dir_out_val);
    end
    @(negedge clk);
    checks++;
    if (move_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_width: got move_err=%b, required 0", move_err);
    end
    drain();
    checks++;
    if (space_loc !== 4'b1010 || move_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL off_edge_state: got loc=%b count=%0d, required 1010 0", space_loc, move_count);
    end
  endtask

  task automatic test_reversal();
    do_reset(1'b1);
    applyStimulus(M_U);
    applyStimulus(M_D);
    applyStimulus(M_L);
    drain();
    checks++;
    if (space_loc !== 4'b0101 || move_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL reversal_state: got loc=%b count=%0d, required 0101 2", space_loc, move_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [5];
    seq = '{M_U, M_L, M_U, M_L, M_D};
    do_reset(1'b0);
    foreach (seq[i]) applyStimulus(seq[i]);
    move_in_val = 1'b1;
    move_in_dir = M_R;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (move_in_rdy !== 1'b0 || dir_out_val !== 1'b1 || dir_out !== M_U) begin
        errors++;
        $display("[TB] FAIL backpressure: got rdy=%b val=%b dir=%b, required 0 1 10",
                 move_in_rdy, dir_out_val, dir_out);
      end
    end
    @(posedge clk);
    #1;
    dir_out_rdy = 1'b1;
    applyStimulus(M_R);
    drain();
    checks++;
    if (move_count !== 16'd6 || space_loc !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL b2b_final: got count=%0d loc=%b, required 6 0101", move_count, space_loc);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    applyStimulus(M_U);
    applyStimulus(M_L);
    applyStimulus(M_U);
    applyStimulus(M_L);
    @(negedge clk);
    checks++;
    if (dir_out_val !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_loaded: got dir_out_val=%b, required 1", dir_out_val);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    err_exp = 0;
    err_seen = 0;
    @(negedge clk);
    checks++;
    if ({move_in_rdy, dir_out_val, dir_out, move_err} !== 5'b10000 ||
        move_count !== 16'd0 || space_loc !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL mid_reset: got rdy/val/dir/err=%b count=%0d loc=%b, required 10000 0 1010",
               {move_in_rdy, dir_out_val, dir_out, move_err}, move_count, space_loc);
    end
    dir_out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (move_count !== 16'd0 || err_seen !== 0) begin
      errors++;
      $display("[TB] FAIL flush: got count=%0d errs=%0d, required 0 0", move_count, err_seen);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5];
    seq = '{M_U, M_L, M_D, M_R, M_U};
    do_reset(1'b1);
    foreach (seq[i]) begin
      s_val = 1'b1;
      s_dir = seq[i];
      @(posedge clk);
      #1;
    end
    s_val = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (s_count !== 2'd3 || s_loc !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL saturation: got count=%0d loc=%b, required 3 0110", s_count, s_loc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_off_edge();
    test_reversal();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
